// File: rtl/irq_key_ctrl.sv
// irq_key_ctrl: synchronizes and debounces N_SRC interrupt lines, latches
// rising edges as pending, and presents one fixed-priority request on key.
//   clk, rst_n    : clock, synchronous active-low reset
//   btn           : raw asynchronous interrupt lines
//   irq_en        : global enable
//   op_m          : trap command (2'b11 = trap taken, acknowledges REQ)
//   trap_done     : MRET retire pulse, ends SERVICE
//   key           : interrupt request level
//   irq_id        : source requested / in service
//   pending       : latched unacknowledged edges
module irq_key_ctrl #(
  parameter int N_SRC    = 4,
  parameter int DEBOUNCE = 4,
  parameter int ID_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  btn,
  input  logic              irq_en,
  input  logic [1:0]        op_m,
  input  logic              trap_done,
  output logic              key,
  output logic [ID_W-1:0]   irq_id,
  output logic [N_SRC-1:0]  pending
);

  localparam int CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  s1_q, s1_d;
  logic [N_SRC-1:0]  s2_q, s2_d;
  logic [N_SRC-1:0]  db_q, db_d;
  logic [N_SRC-1:0]  db_dly_q, db_dly_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [ID_W-1:0]   irq_id_q, irq_id_d;
  logic [CNT_W-1:0]  cnt_q [N_SRC];
  logic [CNT_W-1:0]  cnt_d [N_SRC];

  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  ack_mask;
  logic              ack;
  logic              found;

  // front end: synchronizer, debounce counter, edge detect
  always_comb begin
    s1_d     = btn;
    s2_d     = s1_q;
    db_d     = db_q;
    db_dly_d = db_q;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
          db_d[i]  = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    rise = db_q & ~db_dly_q;
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ack      = 1'b0;
    found    = 1'b0;
    ack_mask = '0;
    case (state_q)
      IDLE: begin
        if (irq_en && (|pending_q)) begin
          for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!found && pending_q[i]) begin
              found    = 1'b1;
              irq_id_d = ID_W'(i);
            end
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (op_m == 2'b11) begin
          ack     = 1'b1;
          state_d = SERVICE;
        end else if (!irq_en) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (trap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    for (int unsigned i = 0; i < N_SRC; i++) begin
      ack_mask[i] = ack && (irq_id_q == ID_W'(i));
    end
    // a same-edge rise overrides the acknowledge clear
    pending_d = (pending_q & ~ack_mask) | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_dly_q  <= '0;
      pending_q <= '0;
      irq_id_q  <= '0;
      cnt_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_dly_q  <= db_dly_d;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign key     = (state_q == REQ);
  assign irq_id  = irq_id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_key_ctrl.sv
module tb_irq_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       irq_en;
  logic [1:0] op_m;
  logic       trap_done;
  logic       key;
  logic [1:0] irq_id;
  logic [3:0] pending;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  irq_key_ctrl #(
    .N_SRC    (4),
    .DEBOUNCE (4),
    .ID_W     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .irq_en    (irq_en),
    .op_m      (op_m),
    .trap_done (trap_done),
    .key       (key),
    .irq_id    (irq_id),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // inputs change right after a negedge; n steps = n posedges elapse
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; btn = 4'hF; irq_en = 1'b1; op_m = 2'b00; trap_done = 1'b0;

    // reset held with all lines high
    step(3);
    check("rst_key", 32'(key), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);

    // release with btn[2]: pending at E6, key at E7
    rst_n = 1'b1; btn = 4'b0100;
    step(7);
    check("lat_key_e6", 32'(key), 32'd0);
    check("lat_pend_e6", 32'(pending), 32'b0100);
    step(1);
    check("lat_key_e7", 32'(key), 32'd1);
    check("lat_id", 32'(irq_id), 32'd2);
    op_m = 2'b11;
    step(1);
    check("ack2_key", 32'(key), 32'd0);
    check("ack2_pend", 32'(pending), 32'd0);
    op_m = 2'b00; trap_done = 1'b1;
    step(1);
    trap_done = 1'b0; btn = 4'b0000;
    step(10);
    check("idle_empty_key", 32'(key), 32'd0);

    // glitch of 3 cycles never debounces
    btn[0] = 1'b1;
    step(3);
    btn[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("glitch_pend", 32'(pending), 32'd0);
      check("glitch_key", 32'(key), 32'd0);
    end

    // priority: 3 and 1 together, 1 served first
    btn = 4'b1010;
    step(7);
    check("pri_pend", 32'(pending), 32'b1010);
    check("pri_key_e6", 32'(key), 32'd0);
    step(1);
    check("pri_key1", 32'(key), 32'd1);
    check("pri_id1", 32'(irq_id), 32'd1);
    op_m = 2'b11;
    step(1);
    op_m = 2'b00;
    check("pri_ack1_key", 32'(key), 32'd0);
    check("pri_ack1_pend", 32'(pending), 32'b1000);
    trap_done = 1'b1;
    step(1);
    trap_done = 1'b0;
    check("pri_td_key", 32'(key), 32'd0);
    step(1);
    check("pri_key3", 32'(key), 32'd1);
    check("pri_id3", 32'(irq_id), 32'd3);
    op_m = 2'b11;
    step(1);
    op_m = 2'b00;
    check("pri_ack3_pend", 32'(pending), 32'b0000);
    trap_done = 1'b1;
    step(1);
    trap_done = 1'b0; btn = 4'b0000;
    step(10);

    // enable gating
    irq_en = 1'b0; btn = 4'b0001;
    step(7);
    check("en_pend", 32'(pending), 32'b0001);
    step(3);
    check("en_key_off", 32'(key), 32'd0);
    irq_en = 1'b1;
    step(1);
    check("en_key_on", 32'(key), 32'd1);
    check("en_id", 32'(irq_id), 32'd0);
    irq_en = 1'b0;
    step(1);
    check("en_drop_key", 32'(key), 32'd0);
    check("en_drop_pend", 32'(pending), 32'b0001);
    irq_en = 1'b1;
    step(1);
    check("en_rereq_key", 32'(key), 32'd1);
    op_m = 2'b11;
    step(1);
    op_m = 2'b00;
    check("en_ack_pend", 32'(pending), 32'b0000);

    // no nesting: new edge and exception op_m in SERVICE
    btn = 4'b0000;
    step(8);
    btn = 4'b0001; op_m = 2'b11;
    step(7);
    check("svc_key", 32'(key), 32'd0);
    check("svc_pend", 32'(pending), 32'b0001);
    step(2);
    check("svc_key_hold", 32'(key), 32'd0);
    op_m = 2'b00; trap_done = 1'b1;
    step(1);
    trap_done = 1'b0;
    check("svc_td_key", 32'(key), 32'd0);
    step(1);
    check("svc_rereq_key", 32'(key), 32'd1);
    check("svc_rereq_id", 32'(irq_id), 32'd0);

    // reset mid-request
    rst_n = 1'b0; btn = 4'b0000;
    step(1);
    check("mid_rst_key", 32'(key), 32'd0);
    check("mid_rst_pend", 32'(pending), 32'd0);
    check("mid_rst_id", 32'(irq_id), 32'd0);
    rst_n = 1'b1;
    step(20);
    check("post_rst_key", 32'(key), 32'd0);
    check("post_rst_pend", 32'(pending), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_key_ctrl.md
# irq_key_ctrl

External interrupt controller that drives the CSR unit's `key` interrupt input. It synchronizes and debounces N raw push-button/IRQ lines and latches their rising edges as pending. It presents one request at a time, with a source id, and holds that request until the CSR takes the trap (`op_m == 2'b11`). It then blocks further requests until the handler returns via MRET.

## Interface
Parameters:
- `N_SRC`, default 4: number of external interrupt lines; allowed range 1..16.
- `DEBOUNCE`, default 4: number of consecutive synchronized samples required to change a debounced level; minimum 1.
- `ID_W`, default 2: width of `irq_id`; must be ≥ clog2(N_SRC), with a minimum of 1.

Ports:
- `clk`  in  1  system clock; all state updates on the posedge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `btn`  in  N_SRC  raw asynchronous interrupt lines, active-high.
- `irq_en`  in  1  global enable; the core drives it with (mie != 0).
- `op_m`  in  2  trap command from the CSR unit; `2'b11` means a trap is being taken.
- `trap_done`  in  1  one-cycle pulse when MRET retires.
- `key`  out  1  interrupt request to the CSR unit, level.
- `irq_id`  out  ID_W  index of the source currently requested or in service.
- `pending`  out  N_SRC  latched, not-yet-acknowledged edges (debug/readback).

## Operation
Per-source front end:
- Synchronizer: 2 flops, `s1` then `s2`.
- Debounce counter, width clog2(DEBOUNCE+1).
  - While `s2 != db[i]`, the counter increments each edge.
  - When `s2 == db[i]`, the counter clears.
  - On the edge where the counter would reach `DEBOUNCE`, `db[i]` takes `s2` and the counter clears.
  - A glitch shorter than DEBOUNCE cycles never changes `db`.
- Edge detect: `rise[i] = db[i] & ~db_q[i]`, where `db_q` is a registered copy of `db`.
- Pending: `rise[i]` sets `pending[i]`; the only thing that clears it is the acknowledge of source i.

State machine (IDLE, REQ, SERVICE):
- **IDLE:** `key = 0`.
  - If `irq_en & |pending`: latch the lowest-index set pending bit into `irq_id` and go to REQ.
- **REQ:** `key = 1`, `irq_id` held stable.
  - If `op_m == 2'b11`: clear `pending[irq_id]` and go to SERVICE. This is the acknowledge.
  - Else if `!irq_en`: go to IDLE; pending is kept.
  - `trap_done` is ignored.
- **SERVICE:** `key = 0`, `irq_id` held.
  - No nesting: new edges still set pending but do not request.
  - On `trap_done`: go to IDLE.
  - `op_m == 2'b11` is ignored, since synchronous exceptions inside the handler are not interrupt acks.

Priority and conflict rules:
- Fixed priority: lower index wins.
- Selection happens only in IDLE; a higher-priority edge arriving during REQ does not retarget `irq_id`.
- `op_m == 2'b11` in IDLE is ignored.

## Timing
Reset values (at any posedge with `rst_n = 0`, including mid-request or mid-service):
- `key = 0`, `irq_id = 0`, `pending = 0`.
- All `s1`, `s2`, `db`, `db_q` and counters are 0; state is IDLE.
- Output behaviour:
  - `key` falls at that edge even if the CSR has not acked.
  - No pending survives reset.

Latency (`btn[i]` goes high and stays high before edge E0, with `irq_en = 1` and state IDLE):
- `s2` goes high at E1.
- `db` goes high at E1+DEBOUNCE.
- `pending[i]` is set at E2+DEBOUNCE.
- `key` rises at E3+DEBOUNCE. With the defaults this is E7.

Handshake:
- `key` falls on the edge that samples `op_m == 2'b11` while in REQ.
- The earliest next `key` rise is 1 edge after `trap_done` is sampled, provided pending is nonzero.

Same-edge conflicts:
- `rise[i]` and ack of source i on the same edge: the set wins, so `pending[i]` stays 1 (the new event is not lost).
- Ack and `irq_en` falling on the same edge: the ack wins, and the FSM goes to SERVICE.
- `trap_done` and a new `rise` on the same edge: go to IDLE with the new pending set; request on the following edge.

## Test plan
- **Reset:** hold `rst_n = 0` for 3 cycles with `btn = 4'hF` → `key = 0`, `irq_id = 0`, `pending = 0`. Release with `btn[2]` high → `key` rises at edge 7 after release; `irq_id = 2`.
- **Glitch:** pulse `btn[0]` high for 3 cycles, then low (DEBOUNCE = 4) → `pending` stays 0 and `key` stays 0 for 20 cycles.
- **Priority:** raise `btn[3]` and `btn[1]` on the same edge → `irq_id = 1` first. After `op_m = 2'b11` then `trap_done`, next request has `irq_id = 3`. `pending` goes 4'b1010 → 4'b1000 → 4'b0000.
- **Enable gating:** `irq_en = 0`, then `btn[0]` edge → `pending = 4'b0001`, `key = 0`. Set `irq_en = 1` → `key = 1` one edge later. Drop `irq_en` in REQ → `key = 0` next edge, with `pending` still 4'b0001.
- **No nesting / conflict:** in SERVICE, edge on `btn[0]` plus `op_m = 2'b11` from an exception → `key` stays 0 and `pending[0] = 1`. Drive `trap_done` → `key = 1` one edge later with `irq_id = 0`.
- **Reset mid-operation:** assert `rst_n = 0` for 1 cycle while in REQ with `key = 1` → `key = 0` and `pending = 0` at that edge; no request afterward unless a new debounced edge occurs.
